// File: rtl/key_schedule_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : key_schedule_seq (with helper key_schedule_sbox)
// Purpose  : AES-128 on-the-fly round-key generator, one round key per request.
//            Build macro KEY_SCHED_BYTE_SERIAL_EN selects one shared S-box
//            (4-cycle key step) instead of four parallel S-boxes (1 cycle).
// Revision : 1.0  initial release
// ============================================================================

module key_schedule_sbox (
   input  logic [7:0] i_byte,
   output logic [7:0] o_byte
);
   localparam logic [2047:0] c_SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

   // Entry 0 sits in the top byte, so (255 - i) * 8 selects entry i.
   assign o_byte = c_SBOX[{~i_byte, 3'b000} +: 8];
endmodule

module key_schedule_seq #(
   parameter int NUM_ROUNDS = 10
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [127:0] key_in,
   input  logic         next_req,
   output logic [127:0] round_key,
   output logic         round_key_valid,
   output logic [3:0]   round_idx,
   output logic         busy,
   output logic         done
);
   localparam logic [3:0] c_LAST = 4'(NUM_ROUNDS);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READY = 2'd1,
      S_CALC  = 2'd2
   } state_t;

   state_t        r_state;
   logic [31:0]   w_rot;
   logic [31:0]   w_sub;
   logic [31:0]   w_t;
   logic [31:0]   w_w0;
   logic [31:0]   w_w1;
   logic [31:0]   w_w2;
   logic [31:0]   w_w3;
   logic [127:0]  w_next_key;
   logic [7:0]    w_rcon;

   function automatic logic [7:0] f_rcon(input logic [3:0] n);
      case (n)
         4'd1:    f_rcon = 8'h01;
         4'd2:    f_rcon = 8'h02;
         4'd3:    f_rcon = 8'h04;
         4'd4:    f_rcon = 8'h08;
         4'd5:    f_rcon = 8'h10;
         4'd6:    f_rcon = 8'h20;
         4'd7:    f_rcon = 8'h40;
         4'd8:    f_rcon = 8'h80;
         4'd9:    f_rcon = 8'h1b;
         4'd10:   f_rcon = 8'h36;
         default: f_rcon = 8'h00;
      endcase
   endfunction

   assign w_rot  = {round_key[23:0], round_key[31:24]};
   assign w_rcon = f_rcon(round_idx + 4'd1);

`ifdef KEY_SCHED_BYTE_SERIAL_EN
   logic [1:0]  r_cnt;
   logic [23:0] r_temp;
   logic [7:0]  w_sbox_in;
   logic [7:0]  w_sbox_out;

   // Byte r_cnt of RotWord, most significant first; the last byte bypasses the temp.
   assign w_sbox_in = w_rot[{~r_cnt, 3'b000} +: 8];
   assign w_sub     = {r_temp, w_sbox_out};

   key_schedule_sbox u_sbox (
      .i_byte (w_sbox_in),
      .o_byte (w_sbox_out)
   );
`else
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_sbox
         key_schedule_sbox u_sbox (
            .i_byte (w_rot[8*gi +: 8]),
            .o_byte (w_sub[8*gi +: 8])
         );
      end
   endgenerate
`endif

   assign w_t        = w_sub ^ {w_rcon, 24'h0};
   assign w_w0       = round_key[127:96] ^ w_t;
   assign w_w1       = round_key[95:64]  ^ w_w0;
   assign w_w2       = round_key[63:32]  ^ w_w1;
   assign w_w3       = round_key[31:0]   ^ w_w2;
   assign w_next_key = {w_w0, w_w1, w_w2, w_w3};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state         <= S_IDLE;
         round_key       <= '0;
         round_key_valid <= 1'b0;
         round_idx       <= 4'd0;
         busy            <= 1'b0;
         done            <= 1'b0;
`ifdef KEY_SCHED_BYTE_SERIAL_EN
         r_cnt           <= 2'd0;
         r_temp          <= '0;
`endif
      end else if (start) begin
         r_state         <= S_READY;
         round_key       <= key_in;
         round_key_valid <= 1'b1;
         round_idx       <= 4'd0;
         busy            <= 1'b0;
         done            <= 1'b0;
`ifdef KEY_SCHED_BYTE_SERIAL_EN
         r_cnt           <= 2'd0;
         r_temp          <= '0;
`endif
      end else begin
         case (r_state)
            S_READY: begin
               if (next_req && (round_idx < c_LAST)) begin
`ifdef KEY_SCHED_BYTE_SERIAL_EN
                  r_state         <= S_CALC;
                  round_key_valid <= 1'b0;
                  busy            <= 1'b1;
                  r_cnt           <= 2'd0;
`else
                  round_key       <= w_next_key;
                  round_idx       <= round_idx + 4'd1;
                  done            <= ((round_idx + 4'd1) == c_LAST);
`endif
               end
            end
`ifdef KEY_SCHED_BYTE_SERIAL_EN
            S_CALC: begin
               r_temp <= {r_temp[15:0], w_sbox_out};
               r_cnt  <= r_cnt + 2'd1;
               if (r_cnt == 2'd3) begin
                  r_state         <= S_READY;
                  round_key       <= w_next_key;
                  round_idx       <= round_idx + 4'd1;
                  round_key_valid <= 1'b1;
                  busy            <= 1'b0;
                  done            <= ((round_idx + 4'd1) == c_LAST);
               end
            end
`endif
            default: ;
         endcase
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_key_schedule_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_key_schedule_seq
// Purpose  : Self-checking bench for key_schedule_seq (NUM_ROUNDS 10 and 4),
//            GF(2^8)-derived reference model, either KEY_SCHED_BYTE_SERIAL_EN build.
// Revision : 1.0  initial release
// ============================================================================
module tb_key_schedule_seq;
`ifdef KEY_SCHED_BYTE_SERIAL_EN
   localparam int c_LAT = 4;
`else
   localparam int c_LAT = 0;
`endif
   localparam logic [127:0] c_KEY_A = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] c_KEY_B = 128'h000102030405060708090a0b0c0d0e0f;

   logic clk = 1'b0;
   logic rst_n, start, next_req;
   logic [127:0] key_in;
   logic [127:0] rk0, rk1;
   logic v0, v1, b0, b1, d0, d1;
   logic [3:0] i0, i1;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   logic [7:0]   sb [256];
   logic [127:0] m_key [2];
   int           m_idx [2];
   bit           m_valid [2];
   int           m_cnt [2];
   int           m_nr [2];

   always #5 clk = ~clk;

   key_schedule_seq #(.NUM_ROUNDS(10)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .start(start), .key_in(key_in), .next_req(next_req),
      .round_key(rk0), .round_key_valid(v0), .round_idx(i0), .busy(b0), .done(d0));

   key_schedule_seq #(.NUM_ROUNDS(4)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .start(start), .key_in(key_in), .next_req(next_req),
      .round_key(rk1), .round_key_valid(v1), .round_idx(i1), .busy(b1), .done(d1));

   function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
      logic [7:0] a, b, p;
      a = a_in; b = b_in; p = 8'h00;
      for (int k = 0; k < 8; k++) begin
         if (b[0]) p = p ^ a;
         a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
         b = b >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
      return (x << n) | (x >> (8 - n));
   endfunction

   function automatic logic [127:0] key_step(input logic [127:0] k, input int idx);
      logic [31:0] w [4];
      logic [31:0] t;
      logic [7:0]  rc;
      for (int j = 0; j < 4; j++) w[j] = k[127 - 32*j -: 32];
      t = {sb[w[3][23:16]], sb[w[3][15:8]], sb[w[3][7:0]], sb[w[3][31:24]]};
      rc = 8'h01;
      for (int j = 0; j < idx; j++) rc = gmul(rc, 8'h02);
      t[31:24] = t[31:24] ^ rc;
      w[0] = w[0] ^ t; w[1] = w[1] ^ w[0]; w[2] = w[2] ^ w[1]; w[3] = w[3] ^ w[2];
      return {w[0], w[1], w[2], w[3]};
   endfunction

   task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: actual=%h expected=%h", nm, $time, act, exp);
      end
   endtask

   // Reference model: a round key advances only through key_step, c_LAT cycles after acceptance.
   always @(posedge clk or negedge rst_n) begin
      for (int n = 0; n < 2; n++) begin
         if (!rst_n) begin
            m_key[n] <= '0; m_idx[n] <= 0; m_valid[n] <= 1'b0; m_cnt[n] <= 0;
         end else if (start) begin
            m_key[n] <= key_in; m_idx[n] <= 0; m_valid[n] <= 1'b1; m_cnt[n] <= 0;
         end else if (m_cnt[n] > 0) begin
            m_cnt[n] <= m_cnt[n] - 1;
            if (m_cnt[n] == 1) begin
               m_key[n]   <= key_step(m_key[n], m_idx[n]);
               m_idx[n]   <= m_idx[n] + 1;
               m_valid[n] <= 1'b1;
            end
         end else if (next_req && m_valid[n] && m_idx[n] < m_nr[n]) begin
            if (c_LAT == 0) begin
               m_key[n] <= key_step(m_key[n], m_idx[n]);
               m_idx[n] <= m_idx[n] + 1;
            end else begin
               m_cnt[n]   <= c_LAT;
               m_valid[n] <= 1'b0;
            end
         end
      end
   end

   task automatic cmp_inst(input int n, input logic [127:0] rk, input logic v,
                           input logic [3:0] idx, input logic b, input logic d);
      string p;
      p = (n == 0) ? "dut0" : "dut1";
      check({p, "_round_key"}, rk, m_key[n]);
      check({p, "_valid"}, 128'(v), 128'(m_valid[n]));
      check({p, "_idx"}, 128'(idx), 128'(m_idx[n]));
      check({p, "_busy"}, 128'(b), 128'(m_cnt[n] > 0));
      check({p, "_done"}, 128'(d), 128'(m_valid[n] && m_idx[n] == m_nr[n]));
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         cmp_inst(0, rk0, v0, i0, b0, d0);
         cmp_inst(1, rk1, v1, i1, b1, d1);
      end
   end

   task automatic do_step();
      int n;
      next_req = 1'b1;
      @(posedge clk); #1;
      next_req = 1'b0;
      n = 0;
      while (!v0 && n < 20) begin
         next_req = 1'($urandom_range(0, 1));
         @(posedge clk); #1;
         n++;
      end
      next_req = 1'b0;
      if (!v0) begin
         checks++; errors++;
         $display("FAIL step_timeout at %0t: valid=%0b after %0d cycles, required 1", $time, v0, n);
      end
   endtask

   initial begin
      logic [7:0] r, s;
      m_nr[0] = 10; m_nr[1] = 4;
      for (int a = 0; a < 256; a++) begin
         r = 8'h01;
         for (int e = 0; e < 254; e++) r = gmul(r, 8'(a));
         s = r ^ rotl8(r, 1) ^ rotl8(r, 2) ^ rotl8(r, 3) ^ rotl8(r, 4) ^ 8'h63;
         sb[a] = s;
      end
      check("model_sbox_00", 128'(sb[8'h00]), 128'h63);
      check("model_sbox_53", 128'(sb[8'h53]), 128'hed);
      check("model_step1", key_step(c_KEY_A, 0), 128'ha0fafe1788542cb123a339392a6c7605);

      rst_n = 1'b0; start = 1'b0; next_req = 1'b0; key_in = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_round_key", rk0, '0);
      check("reset_valid_idx_busy_done", {v0, i0, b0, d0}, '0);
      rst_n = 1'b1;
      chk_en = 1'b1;

      // FIPS-197 key expansion walk
      @(posedge clk); #1;
      next_req = 1'b1;
      @(posedge clk); #1;
      next_req = 1'b0;
      check("pre_start_valid", 128'(v0), 128'h0);
      start = 1'b1; key_in = c_KEY_A;
      @(posedge clk); #1;
      start = 1'b0;
      check("start_round_key", rk0, c_KEY_A);
      check("start_idx_valid_done", {i0, v0, d0}, {4'd0, 1'b1, 1'b0});
      for (int i = 1; i <= 10; i++) begin
         do_step();
         if (i == 1) check("round1_key", rk0, 128'ha0fafe1788542cb123a339392a6c7605);
         if (i == 4) begin
            check("nr4_round_key", rk1, 128'hef44a541a8525b7fb671253bdb0bad00);
            check("nr4_idx_done", {i1, d1}, {4'd4, 1'b1});
         end
      end
      check("round10_key", rk0, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      check("round10_idx_done", {i0, d0}, {4'd10, 1'b1});
      do_step();
      check("extra_req_key", rk0, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      check("extra_req_idx", 128'(i0), 128'd10);

      // start overriding an in-flight step
      start = 1'b1; key_in = c_KEY_A;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) do_step();
      if (c_LAT == 0) begin
         start = 1'b1; next_req = 1'b1; key_in = c_KEY_B;
         @(posedge clk); #1;
      end else begin
         next_req = 1'b1;
         @(posedge clk); #1;
         next_req = 1'b0;
         @(posedge clk); #1;
         start = 1'b1; key_in = c_KEY_B;
         @(posedge clk); #1;
      end
      start = 1'b0; next_req = 1'b0;
      check("restart_key", rk0, c_KEY_B);
      check("restart_idx_busy_valid", {i0, b0, v0}, {4'd0, 1'b0, 1'b1});

      // asynchronous reset at idx 5, then mid-step
      repeat (5) do_step();
      check("pre_reset_idx", 128'(i0), 128'd5);
      #2 rst_n = 1'b0;
      #1;
      check("async_reset_key", rk0, '0);
      check("async_reset_flags", {v0, i0, b0, d0, v1, i1, b1, d1}, '0);
      @(posedge clk); #1 rst_n = 1'b1;
      start = 1'b1; key_in = c_KEY_A;
      @(posedge clk); #1;
      start = 1'b0; next_req = 1'b1;
      @(posedge clk); #1;
      next_req = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("async_reset_mid_step", {rk0, v0, i0, b0, d0}, '0);
      @(posedge clk); #1 rst_n = 1'b1;
      next_req = 1'b1;
      repeat (3) @(posedge clk);
      #1 next_req = 1'b0;
      check("post_reset_ignore", {v0, i0}, '0);

      // randomized traffic
      for (int c = 0; c < 500; c++) begin
         start    = (c == 0) || ($urandom_range(0, 29) == 0);
         key_in   = {$urandom(), $urandom(), $urandom(), $urandom()};
         next_req = 1'($urandom_range(0, 1));
         @(posedge clk); #1;
      end
      start = 1'b0; next_req = 1'b0;
      @(negedge clk);
      chk_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
